// File: rtl/io_pkg.sv
// io_pkg: shared board-level timing constants for the input conditioner.
package io_pkg;
    localparam int CLK_FREQ_HZ = 50_000_000;
    localparam int DEBOUNCE_MS = 20;
    localparam int N_REG_SEL = 5;
    localparam int DEBOUNCE_CYCLES_DEF = CLK_FREQ_HZ / 1000 * DEBOUNCE_MS;
endpackage

// File: rtl/fpga_input_conditioner_if.sv
// fpga_input_conditioner_if: raw board inputs and conditioned outputs of the front end.
interface fpga_input_conditioner_if import io_pkg::*; #(
    parameter int N_SW = N_REG_SEL
);
    logic [N_SW-1:0] SW_raw;
    logic mode_run_raw;
    logic KEY_step_n;
    logic [N_SW-1:0] reg_sel;
    logic sw_changed;
    logic mode_run;
    logic step_pulse;
    logic cpu_en;
    modport master (
        output SW_raw, mode_run_raw, KEY_step_n,
        input reg_sel, sw_changed, mode_run, step_pulse, cpu_en
    );
    modport slave (
        input SW_raw, mode_run_raw, KEY_step_n,
        output reg_sel, sw_changed, mode_run, step_pulse, cpu_en
    );
endinterface

// File: rtl/debounce_bit.sv
// debounce_bit: 2-flop synchroniser plus consecutive-stable-cycle debouncer for one input.
module debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 1,
    parameter int CNT_W = 1,
    parameter bit RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic stable_o,
    output logic flip_o
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    logic sync1_q, sync2_q, stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // flip_o flags the edge on which stable_q takes the new level
    always_comb begin
        flip_o = (sync2_q != stable_q) && (cnt_q == LAST);
        stable_d = flip_o ? sync2_q : stable_q;
        cnt_d = (sync2_q == stable_q || flip_o) ? '0 : cnt_q + 1'b1;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= RESET_VAL;
            sync2_q <= RESET_VAL;
            stable_q <= RESET_VAL;
            cnt_q <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            stable_q <= stable_d;
            cnt_q <= cnt_d;
        end
    end
    assign stable_o = stable_q;
endmodule

// File: rtl/fpga_input_conditioner.sv
// fpga_input_conditioner: debounced switches/button, register select and CPU clock-enable.
module fpga_input_conditioner import io_pkg::*; #(
    parameter int N_SW = N_REG_SEL,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int RUN_DIV = 1,
    parameter int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input logic clk,
    input logic reset,
    fpga_input_conditioner_if.slave io
);
    localparam int NB = N_SW + 2;
    localparam int DIV_W = RUN_DIV > 1 ? $clog2(RUN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);
    logic [NB-1:0] raw, stable, flip;
    logic key_stable, mode_run, unused_flips;
    logic key_prev_q, step_pulse_q, sw_changed_q, cpu_en_q;
    logic step_pulse_d, sw_changed_d, cpu_en_d;
    logic [DIV_W-1:0] div_q, div_d;
    assign raw = {io.KEY_step_n, io.mode_run_raw, io.SW_raw};
    // the button bit idles high (released); every other bit idles low
    for (genvar i = 0; i < NB; i++) begin : g_db
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W(CNT_W),
            .RESET_VAL(i == NB - 1)
        ) u_db (
            .clk(clk),
            .reset(reset),
            .raw_i(raw[i]),
            .stable_o(stable[i]),
            .flip_o(flip[i])
        );
    end
    assign key_stable = stable[NB-1];
    assign mode_run = stable[N_SW];
    assign unused_flips = ^flip[NB-1:N_SW];
    always_comb begin
        step_pulse_d = key_prev_q & ~key_stable;
        sw_changed_d = |flip[N_SW-1:0];
        div_d = !mode_run ? '0 : (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        cpu_en_d = mode_run ? (div_q == DIV_LAST) : step_pulse_d;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            key_prev_q <= 1'b1;
            step_pulse_q <= 1'b0;
            sw_changed_q <= 1'b0;
            cpu_en_q <= 1'b0;
            div_q <= '0;
        end else begin
            key_prev_q <= key_stable;
            step_pulse_q <= step_pulse_d;
            sw_changed_q <= sw_changed_d;
            cpu_en_q <= cpu_en_d;
            div_q <= div_d;
        end
    end
    assign io.reg_sel = stable[N_SW-1:0];
    assign io.sw_changed = sw_changed_q;
    assign io.mode_run = mode_run;
    assign io.step_pulse = step_pulse_q;
    assign io.cpu_en = cpu_en_q;
endmodule

// File: tb/tb_fpga_input_conditioner.sv
// tb_fpga_input_conditioner: directed scenarios plus random stimulus against a window-based reference model.
module tb_fpga_input_conditioner;
    localparam int N = 5;
    localparam int D = 4;
    localparam int R = 3;
    localparam logic [6:0] RST_V = 7'b100_0000;
    logic clk = 1'b0;
    logic reset;
    int n_checks = 0;
    int n_fail = 0;
    always #5 clk = ~clk;
    fpga_input_conditioner_if #(.N_SW(N)) io ();
    fpga_input_conditioner #(
        .N_SW(N),
        .DEBOUNCE_CYCLES(D),
        .RUN_DIV(R)
    ) dut (
        .clk(clk),
        .reset(reset),
        .io(io)
    );
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask
    // Reference: a level is accepted once the last D synchronised samples all differ from it.
    logic [6:0] hist[$];
    logic [6:0] m_stable;
    logic m_sw_changed, m_step, m_cpu_en, m_fell;
    int edge_n = 0;
    int rise_e = 0;
    bit started = 0;
    always @(posedge clk) begin
        logic [6:0] nxt;
        logic pre_mode, diff;
        if (reset) begin
            hist.delete();
            for (int i = 0; i < D + 2; i++) hist.push_front(RST_V);
            m_stable = RST_V;
            m_sw_changed = 0;
            m_step = 0;
            m_cpu_en = 0;
            m_fell = 0;
        end else begin
            pre_mode = m_stable[5];
            nxt = m_stable;
            for (int b = 0; b < 7; b++) begin
                diff = 1;
                for (int i = 1; i <= D; i++) if (hist[i][b] == m_stable[b]) diff = 0;
                if (diff) nxt[b] = hist[1][b];
            end
            m_sw_changed = (nxt[4:0] != m_stable[4:0]);
            m_step = m_fell;
            m_fell = m_stable[6] & ~nxt[6];
            m_cpu_en = pre_mode ? ((edge_n - rise_e) % R == 0) : m_step;
            if (!m_stable[5] && nxt[5]) rise_e = edge_n;
            m_stable = nxt;
            hist.push_front({io.KEY_step_n, io.mode_run_raw, io.SW_raw});
            void'(hist.pop_back());
        end
        edge_n++;
        started = 1;
    end
    always @(negedge clk) begin
        if (started) begin
            check("reg_sel", 32'(io.reg_sel), 32'(m_stable[4:0]));
            check("sw_changed", 32'(io.sw_changed), 32'(m_sw_changed));
            check("mode_run", 32'(io.mode_run), 32'(m_stable[5]));
            check("step_pulse", 32'(io.step_pulse), 32'(m_step));
            check("cpu_en", 32'(io.cpu_en), 32'(m_cpu_en));
        end
    end
    int c_step, c_en;
    initial begin
        reset = 1;
        io.SW_raw = 5'h1F;
        io.mode_run_raw = 0;
        io.KEY_step_n = 0;
        repeat (3) begin
            @(negedge clk);
            check("rst_reg_sel", 32'(io.reg_sel), 32'd0);
            check("rst_cpu_en", 32'(io.cpu_en), 32'd0);
            check("rst_step", 32'(io.step_pulse), 32'd0);
            check("rst_swchg", 32'(io.sw_changed), 32'd0);
        end
        reset = 0;
        io.SW_raw = 0;
        io.KEY_step_n = 1;
        repeat (10) @(negedge clk);
        // clean change: visible exactly 6 edges after capture
        io.SW_raw = 5'd8;
        repeat (5) @(posedge clk);
        #1 check("lat_early", 32'(io.reg_sel), 32'd0);
        @(posedge clk);
        #1 check("lat_val", 32'(io.reg_sel), 32'd8);
        check("lat_swchg", 32'(io.sw_changed), 32'd1);
        @(posedge clk);
        #1 check("lat_swchg_end", 32'(io.sw_changed), 32'd0);
        // bounce on bit0: 1,1,1,0 then steady 1
        @(negedge clk);
        io.SW_raw = 5'd9;
        repeat (3) @(negedge clk);
        io.SW_raw = 5'd8;
        @(negedge clk);
        io.SW_raw = 5'd9;
        c_en = 0;
        repeat (5) begin
            @(posedge clk);
            #1 c_en += int'(io.sw_changed);
        end
        check("bounce_hold", 32'(io.reg_sel), 32'd8);
        @(posedge clk);
        #1 check("bounce_val", 32'(io.reg_sel), 32'd9);
        c_en += int'(io.sw_changed);
        repeat (6) begin
            @(posedge clk);
            #1 c_en += int'(io.sw_changed);
        end
        check("bounce_pulses", 32'(c_en), 32'd1);
        // step mode: one press gives one pulse, release gives none
        @(negedge clk);
        io.KEY_step_n = 0;
        c_step = 0;
        c_en = 0;
        repeat (20) begin
            @(negedge clk);
            c_step += int'(io.step_pulse);
            c_en += int'(io.cpu_en);
        end
        check("press_pulses", 32'(c_step), 32'd1);
        check("press_cpu_en", 32'(c_en), 32'd1);
        io.KEY_step_n = 1;
        c_step = 0;
        c_en = 0;
        repeat (20) begin
            @(negedge clk);
            c_step += int'(io.step_pulse);
            c_en += int'(io.cpu_en);
        end
        check("release_pulses", 32'(c_step), 32'd0);
        check("release_cpu_en", 32'(c_en), 32'd0);
        // run mode: cpu_en every R cycles, presses do not add enables
        io.mode_run_raw = 1;
        repeat (20) @(negedge clk);
        c_en = 0;
        repeat (9) begin
            @(negedge clk);
            c_en += int'(io.cpu_en);
        end
        check("run_cpu_en", 32'(c_en), 32'd3);
        io.KEY_step_n = 0;
        c_step = 0;
        c_en = 0;
        repeat (24) begin
            @(negedge clk);
            if (c_step + c_en == 12) io.KEY_step_n = 1;
            c_step += int'(io.step_pulse);
            c_en += int'(io.cpu_en);
        end
        check("run_press_step", 32'(c_step), 32'd1);
        check("run_press_cpu_en", 32'(c_en), 32'd8);
        io.KEY_step_n = 1;
        io.mode_run_raw = 0;
        repeat (8) @(negedge clk);
        c_en = 0;
        repeat (20) begin
            @(negedge clk);
            c_en += int'(io.cpu_en);
        end
        check("step_idle_cpu_en", 32'(c_en), 32'd0);
        // reset mid-debounce discards progress
        io.SW_raw = 5'd3;
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        check("mid_rst_reg_sel", 32'(io.reg_sel), 32'd0);
        repeat (5) @(posedge clk);
        #1 check("post_rst_early", 32'(io.reg_sel), 32'd0);
        @(posedge clk);
        #1 check("post_rst_val", 32'(io.reg_sel), 32'd3);
        // random soak, model checked every cycle
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 40) == 0);
            io.SW_raw = 5'($urandom);
            if ($urandom_range(0, 7) == 0) io.mode_run_raw = ~io.mode_run_raw;
            io.KEY_step_n = 1'($urandom);
            repeat ($urandom_range(0, 9)) begin
                @(negedge clk);
                reset = 0;
            end
            reset = 0;
        end
        repeat (10) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
